// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and helpers for the bit-serial adder.
//   state_t       : controller states (IDLE / RUN / DONE)
//   WIDTH_DEFAULT : default operand width
//   maj3()        : 3-input majority, the carry function of a full adder
// Optional feature macro: SERIAL_ADDER_SUB_EN (see bit_add_cell / serial_adder)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
// Request/result bundle for serial_adder.
//   start : request, sampled only while the adder is idle
//   a, b  : WIDTH-bit operands, captured on the accepted start
//   sub   : subtract select (only with SERIAL_ADDER_SUB_EN defined)
//   busy  : operation in progress (RUN or DONE)
//   done  : one-cycle pulse, sum/cout final
//   sum   : WIDTH-bit result, held until the next accepted start
//   cout  : carry-out (borrow-out when subtracting)
// Modports: master drives requests, slave is the adder.
// Optional feature macro: SERIAL_ADDER_SUB_EN
// -----------------------------------------------------------------------------
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
   modport master (output start, a, b, sub, input  busy, done, sum, cout);
   modport slave  (input  start, a, b, sub, output busy, done, sum, cout);
`else
   modport master (output start, a, b, input  busy, done, sum, cout);
   modport slave  (input  start, a, b, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_cell.sv
// -----------------------------------------------------------------------------
// bit_add_cell
// Single combinational full-adder cell used by serial_adder, one bit per clock.
//   i_x, i_y : operand bits
//   i_cin    : carry (borrow) in
//   i_sub    : 1 = full-subtractor (only with SERIAL_ADDER_SUB_EN defined)
//   o_s      : sum / difference bit
//   o_co     : carry / borrow out
// Optional feature macro: SERIAL_ADDER_SUB_EN
// -----------------------------------------------------------------------------
module bit_add_cell
   import serial_adder_pkg::*;
(
   input  logic i_x,
   input  logic i_y,
   input  logic i_cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic i_sub,
`endif
   output logic o_s,
   output logic o_co
);

   // Sum and difference bits share the same XOR.
   assign o_s = i_x ^ i_y ^ i_cin;

`ifdef SERIAL_ADDER_SUB_EN
   // Borrow (~x&y)|(y&bin)|(~x&bin) is the majority of ~x, y, bin.
   assign o_co = maj3(i_x ^ i_sub, i_y, i_cin);
`else
   assign o_co = maj3(i_x, i_y, i_cin);
`endif

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: captures two WIDTH-bit operands on start, adds them
// LSB-first one bit per clock through a single cell with a registered carry,
// then pulses done with a parallel sum and carry-out.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : serial_adder_if.slave (start, a, b, [sub], busy, done, sum, cout)
// Parameter WIDTH : operand width, 2..32.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds bus.sub, a-b mode)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; sum/cout hold the last result
// ST_RUN  | WIDTH serial steps, one operand bit pair per clock
// ST_DONE | one cycle, done=1, result final
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
)
(
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               w_s;
   logic               w_co;
   logic               w_last;
`ifdef SERIAL_ADDER_SUB_EN
   logic               r_sub;
`endif

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   bit_add_cell u_cell (
      .i_x   (r_a_sh[0]),
      .i_y   (r_b_sh[0]),
      .i_cin (r_carry),
`ifdef SERIAL_ADDER_SUB_EN
      .i_sub (r_sub),
`endif
      .o_s   (w_s),
      .o_co  (w_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (bus.start) w_next_state = ST_RUN;
         ST_RUN:  if (w_last)    w_next_state = ST_DONE;
         ST_DONE:                w_next_state = ST_IDLE;
         default:                w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (r_state)
         ST_RUN:  bus.busy = 1'b1;
         ST_DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;

   // Datapath: operand shifters, carry, step counter and result.
   // cout is left alone on capture; it is only meaningful once done pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         r_sub   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_a_sh  <= bus.a;
                  r_b_sh  <= bus.b;
                  r_carry <= 1'b0;
                  r_cnt   <= '0;
                  r_sum   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                  r_sub   <= bus.sub;
`endif
               end
            end
            ST_RUN: begin
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               // New bit enters at the MSB; after WIDTH steps bit 0 lands at sum[0].
               r_sum   <= {w_s, r_sum[WIDTH-1:1]};
               r_carry <= w_co;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) r_cout <= w_co;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
   import serial_adder_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(W)) bus ();

   serial_adder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] s, input logic c);
      vec_t v;
      v.a = a; v.b = b; v.sub = sub; v.exp_sum = s; v.exp_cout = c;
      vecs.push_back(v);
   endtask

   task automatic drive_sub(input logic sub);
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub = sub;
`else
      if (sub) $fatal(1, "FAIL drive_sub: subtract vector in add-only build");
`endif
   endtask

   // One full operation; operands are scrambled right after capture.
   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] es, input logic ec);
      int cyc;
      int busy_cnt;
      bit seen;
      @(negedge clk);
      bus.a = a; bus.b = b; drive_sub(sub); bus.start = 1'b1;
      @(posedge clk);
      cyc = 0; busy_cnt = 0; seen = 0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         if (cyc == 0) begin
            bus.start = 1'b0; bus.a = ~a; bus.b = ~b;
         end
         cyc++;
         if (bus.busy) busy_cnt++;
         if (bus.done) seen = 1;
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      check({name, "_latency"}, 32'(cyc), 32'(W + 1));
      check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
      check({name, "_sum"}, 32'(bus.sum), 32'(es));
      check({name, "_cout"}, 32'(bus.cout), 32'(ec));
      @(negedge clk);
      check({name, "_done_single"}, 32'(bus.done), 32'd0);
      check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
      check({name, "_sum_held"}, 32'(bus.sum), 32'(es));
      check({name, "_cout_held"}, 32'(bus.cout), 32'(ec));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone;
      int done_at;
      int last_done;
      int cnt;

      add_vec(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      add_vec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      add_vec(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      add_vec(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
      add_vec(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
      add_vec(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
      add_vec(8'h10, 8'h01, 1'b1, 8'h0F, 1'b0);
      add_vec(8'h00, 8'h01, 1'b1, 8'hFF, 1'b1);
      add_vec(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      add_vec(8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0);
      add_vec(8'h01, 8'h02, 1'b1, 8'hFF, 1'b1);
`endif
      add_vec(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

      rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; drive_sub(1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_sum", 32'(bus.sum), 32'd0);
      check("reset_cout", 32'(bus.cout), 32'd0);

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                vecs[i].exp_sum, vecs[i].exp_cout);

      // start pulsed with new operands mid-RUN must be ignored
      @(negedge clk);
      bus.a = 8'h5A; bus.b = 8'h3C; drive_sub(1'b0); bus.start = 1'b1;
      @(posedge clk);
      ndone = 0; done_at = 0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i == 1) bus.start = 1'b0;
         if (i == 3) begin bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1; end
         if (i == 4) bus.start = 1'b0;
         if (bus.done) begin
            ndone++;
            if (ndone == 1) begin
               done_at = i;
               check("midrun_sum", 32'(bus.sum), 32'h96);
               check("midrun_cout", 32'(bus.cout), 32'd0);
            end
         end
      end
      check("midrun_done_count", 32'(ndone), 32'd1);
      check("midrun_done_at", 32'(done_at), 32'(W + 1));
      check("midrun_sum_after", 32'(bus.sum), 32'h96);

      // abort by reset three cycles into RUN; leave cout=1 beforehand
      run_op("pre_abort", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      bus.a = 8'h5A; bus.b = 8'h3C; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_midrun_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_sum", 32'(bus.sum), 32'd0);
      check("abort_cout", 32'(bus.cout), 32'd0);
      ndone = 0;
      if (bus.done) ndone++;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      run_op("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

      // start held high: one operation every W+2 cycles
      @(negedge clk);
      bus.a = 8'h11; bus.b = 8'h22; drive_sub(1'b0); bus.start = 1'b1;
      @(posedge clk);
      ndone = 0; done_at = 0; last_done = 0;
      for (int i = 1; i <= 35; i++) begin
         @(negedge clk);
         if (bus.done) begin
            ndone++;
            if (ndone == 1) check("b2b_first_done", 32'(i), 32'(W + 1));
            else check($sformatf("b2b_interval%0d", ndone), 32'(i - last_done), 32'(W + 2));
            check($sformatf("b2b_sum%0d", ndone), 32'(bus.sum), 32'h33);
            if (i - last_done == 1 && ndone > 1) check("b2b_pulse_width", 32'd2, 32'd1);
            last_done = i;
         end
      end
      check("b2b_done_count", 32'(ndone), 32'd3);
      bus.start = 1'b0;
      cnt = 0;
      while (bus.busy && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("b2b_return_idle", 32'(bus.busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
